// File: rtl/trap_sequencer_if.sv
// ============================================================================
// Module : trap_sequencer_if
// Brief  : Request/datapath-control bundle between control unit and trap sequencer
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface trap_sequencer_if;
    logic       illegal_op;
    logic       alu_ovf;
    logic       trap_busy;
    logic       trap_done;
    logic [1:0] trap_cause;
    logic       double_fault;
    logic [2:0] AluSrcA;
    logic [2:0] AluSrcB;
    logic [2:0] AluFct;
    logic       writeEPC;
    logic       PCWrite;
    logic       WriteRegBanco;
    logic [2:0] loadToMem32;
    logic [2:0] loadToPC;
    logic [2:0] regToBan;
    logic [2:0] MemToReg;

    modport master (
        output illegal_op, alu_ovf,
        input  trap_busy, trap_done, trap_cause, double_fault,
        input  AluSrcA, AluSrcB, AluFct, writeEPC, PCWrite, WriteRegBanco,
        input  loadToMem32, loadToPC, regToBan, MemToReg
    );

    modport slave (
        input  illegal_op, alu_ovf,
        output trap_busy, trap_done, trap_cause, double_fault,
        output AluSrcA, AluSrcB, AluFct, writeEPC, PCWrite, WriteRegBanco,
        output loadToMem32, loadToPC, regToBan, MemToReg
    );
endinterface

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module : trap_sequencer
// Brief  : Multi-cycle trap entry sequencer (EPC save, vector fetch, PC load).
//          Define TRAP_CAUSE_WRITE_EN to add a state that writes the cause to x30.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer (
    input  logic             clock,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_ILL  = 2'b01;
    localparam logic [1:0] c_CAUSE_OVF  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_SAVE_EPC    = 3'd1,
        S_FETCH_VEC   = 3'd2,
        S_WAIT_MEM    = 3'd3,
        S_LOAD_PC     = 3'd4,
        S_DONE        = 3'd5
`ifdef TRAP_CAUSE_WRITE_EN
        , S_WRITE_CAUSE = 3'd6
`endif
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_cause;
    logic [1:0] w_nextCause;

    logic       r_illPrev;
    logic       r_ovfPrev;
    logic       r_doubleFault;
    logic       w_newReq;

    logic       w_busy, w_done, w_writeEPC, w_pcWrite;
    logic [2:0] w_aluSrcA, w_aluSrcB, w_aluFct, w_loadToMem32, w_loadToPC, w_vecSel;
    logic       r_busy, r_done, r_writeEPC, r_pcWrite;
    logic [2:0] r_aluSrcA, r_aluSrcB, r_aluFct, r_loadToMem32, r_loadToPC;

`ifdef TRAP_CAUSE_WRITE_EN
    logic       w_writeRegBanco, r_writeRegBanco;
    logic [2:0] w_regToBan, w_memToReg, r_regToBan, r_memToReg;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cause <= c_CAUSE_NONE;
        end else begin
            r_state <= w_nextState;
            r_cause <= w_nextCause;
        end
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        w_nextState   = r_state;
        w_nextCause   = r_cause;
        w_busy        = 1'b0;
        w_done        = 1'b0;
        w_writeEPC    = 1'b0;
        w_pcWrite     = 1'b0;
        w_aluSrcA     = 3'b000;
        w_aluSrcB     = 3'b000;
        w_aluFct      = 3'b000;
        w_loadToMem32 = 3'b000;
        w_loadToPC    = 3'b000;
`ifdef TRAP_CAUSE_WRITE_EN
        w_writeRegBanco = 1'b0;
        w_regToBan      = 3'b000;
        w_memToReg      = 3'b000;
`endif

        case (r_state)
            S_IDLE: begin
                if (bus.illegal_op) begin
                    w_nextState = S_SAVE_EPC;
                    w_nextCause = c_CAUSE_ILL;
                end else if (bus.alu_ovf) begin
                    w_nextState = S_SAVE_EPC;
                    w_nextCause = c_CAUSE_OVF;
                end else begin
                    w_nextCause = c_CAUSE_NONE;
                end
            end
            S_SAVE_EPC:  w_nextState = S_FETCH_VEC;
            S_FETCH_VEC: w_nextState = S_WAIT_MEM;
            S_WAIT_MEM:  w_nextState = S_LOAD_PC;
`ifdef TRAP_CAUSE_WRITE_EN
            S_LOAD_PC:     w_nextState = S_WRITE_CAUSE;
            S_WRITE_CAUSE: w_nextState = S_DONE;
`else
            S_LOAD_PC:     w_nextState = S_DONE;
`endif
            S_DONE: begin
                w_nextState = S_IDLE;
                w_nextCause = c_CAUSE_NONE;
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextCause = c_CAUSE_NONE;
            end
        endcase

        // Vector word 254 for illegal opcode, 255 for overflow
        w_vecSel = (w_nextCause == c_CAUSE_ILL) ? 3'd1 : 3'd2;
        w_busy   = (w_nextState != S_IDLE);

        case (w_nextState)
            S_SAVE_EPC: begin
                w_aluSrcA  = 3'd0;
                w_aluSrcB  = 3'd3;
                w_aluFct   = 3'b001;
                w_writeEPC = 1'b1;
            end
            S_FETCH_VEC: w_loadToMem32 = w_vecSel;
            S_WAIT_MEM:  w_loadToMem32 = w_vecSel;
            S_LOAD_PC: begin
                w_loadToMem32 = w_vecSel;
                w_loadToPC    = 3'd1;
                w_pcWrite     = 1'b1;
            end
`ifdef TRAP_CAUSE_WRITE_EN
            S_WRITE_CAUSE: begin
                w_regToBan      = 3'd1;
                w_writeRegBanco = 1'b1;
                w_memToReg      = (w_nextCause == c_CAUSE_ILL) ? 3'd3 : 3'd4;
            end
`endif
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    // A request counts as new only on its rising edge, so a level held from
    // the trap that is already running is not mistaken for a second fault.
    assign w_newReq = (bus.illegal_op & ~r_illPrev) | (bus.alu_ovf & ~r_ovfPrev);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_writeEPC    <= 1'b0;
            r_pcWrite     <= 1'b0;
            r_aluSrcA     <= 3'b000;
            r_aluSrcB     <= 3'b000;
            r_aluFct      <= 3'b000;
            r_loadToMem32 <= 3'b000;
            r_loadToPC    <= 3'b000;
            r_illPrev     <= 1'b0;
            r_ovfPrev     <= 1'b0;
            r_doubleFault <= 1'b0;
        end else begin
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_writeEPC    <= w_writeEPC;
            r_pcWrite     <= w_pcWrite;
            r_aluSrcA     <= w_aluSrcA;
            r_aluSrcB     <= w_aluSrcB;
            r_aluFct      <= w_aluFct;
            r_loadToMem32 <= w_loadToMem32;
            r_loadToPC    <= w_loadToPC;
            r_illPrev     <= bus.illegal_op;
            r_ovfPrev     <= bus.alu_ovf;
            if (r_busy && w_newReq) begin
                r_doubleFault <= 1'b1;
            end
        end
    end

`ifdef TRAP_CAUSE_WRITE_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_writeRegBanco <= 1'b0;
            r_regToBan      <= 3'b000;
            r_memToReg      <= 3'b000;
        end else begin
            r_writeRegBanco <= w_writeRegBanco;
            r_regToBan      <= w_regToBan;
            r_memToReg      <= w_memToReg;
        end
    end

    assign bus.WriteRegBanco = r_writeRegBanco;
    assign bus.regToBan      = r_regToBan;
    assign bus.MemToReg      = r_memToReg;
`else
    assign bus.WriteRegBanco = 1'b0;
    assign bus.regToBan      = 3'b000;
    assign bus.MemToReg      = 3'b000;
`endif

    assign bus.trap_busy    = r_busy;
    assign bus.trap_done    = r_done;
    assign bus.trap_cause   = r_cause;
    assign bus.double_fault = r_doubleFault;
    assign bus.AluSrcA      = r_aluSrcA;
    assign bus.AluSrcB      = r_aluSrcB;
    assign bus.AluFct       = r_aluFct;
    assign bus.writeEPC     = r_writeEPC;
    assign bus.PCWrite      = r_pcWrite;
    assign bus.loadToMem32  = r_loadToMem32;
    assign bus.loadToPC     = r_loadToPC;

endmodule

`default_nettype wire
